// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-ported memory between the fetch (if) and data (dm) ports.
// Each transaction owns the memory until mem_ack arrives or the BUSY timeout aborts it.
module mem_port_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [DW-1:0] if_rdata,
  output logic          if_ack,
  output logic          if_err,
  input  logic          dm_req,
  input  logic          dm_we,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  output logic [DW-1:0] dm_rdata,
  output logic          dm_ack,
  output logic          dm_err,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ack,
  output logic          grant_dm
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_t        state_q, state_d;
  logic          mem_req_q, mem_req_d;
  logic          mem_we_q, mem_we_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic          grant_dm_q, grant_dm_d;
  logic          last_grant_q, last_grant_d;
  logic [7:0]    cnt_q, cnt_d;
  logic [DW-1:0] if_rdata_q, if_rdata_d;
  logic [DW-1:0] dm_rdata_q, dm_rdata_d;
  logic          if_ack_q, if_ack_d;
  logic          if_err_q, if_err_d;
  logic          dm_ack_q, dm_ack_d;
  logic          dm_err_q, dm_err_d;

  logic pick_dm;
  logic timeout_hit;

  // On contention the port that was not served last wins.
  assign pick_dm     = dm_req & (~if_req | ~last_grant_q);
  assign timeout_hit = (cnt_q == TO_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      grant_dm_q   <= 1'b0;
      last_grant_q <= 1'b1;
      cnt_q        <= '0;
      if_rdata_q   <= '0;
      dm_rdata_q   <= '0;
      if_ack_q     <= 1'b0;
      if_err_q     <= 1'b0;
      dm_ack_q     <= 1'b0;
      dm_err_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      grant_dm_q   <= grant_dm_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      if_rdata_q   <= if_rdata_d;
      dm_rdata_q   <= dm_rdata_d;
      if_ack_q     <= if_ack_d;
      if_err_q     <= if_err_d;
      dm_ack_q     <= dm_ack_d;
      dm_err_q     <= dm_err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (if_req || dm_req) state_d = BUSY;
      BUSY:    if (mem_ack || timeout_hit) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    grant_dm_d   = grant_dm_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    if_rdata_d   = if_rdata_q;
    dm_rdata_d   = dm_rdata_q;
    if_ack_d     = 1'b0;
    if_err_d     = 1'b0;
    dm_ack_d     = 1'b0;
    dm_err_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (if_req || dm_req) begin
          grant_dm_d   = pick_dm;
          last_grant_d = pick_dm;
          mem_req_d    = 1'b1;
          mem_we_d     = pick_dm & dm_we;
          mem_addr_d   = pick_dm ? dm_addr : if_addr;
          mem_wdata_d  = pick_dm ? dm_wdata : '0;
          cnt_d        = '0;
        end
      end
      BUSY: begin
        cnt_d = cnt_q + 8'd1;
        // A late ack in the final BUSY cycle still counts as success.
        if (mem_ack || timeout_hit) begin
          mem_req_d = 1'b0;
          if (grant_dm_q) begin
            dm_ack_d   = 1'b1;
            dm_err_d   = ~mem_ack;
            dm_rdata_d = (mem_ack && !mem_we_q) ? mem_rdata : '0;
          end else begin
            if_ack_d   = 1'b1;
            if_err_d   = ~mem_ack;
            if_rdata_d = mem_ack ? mem_rdata : '0;
          end
        end
      end
      default: ;
    endcase
  end

  assign if_rdata  = if_rdata_q;
  assign if_ack    = if_ack_q;
  assign if_err    = if_err_q;
  assign dm_rdata  = dm_rdata_q;
  assign dm_ack    = dm_ack_q;
  assign dm_err    = dm_err_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign grant_dm  = grant_dm_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter: requesters and memory are driven from a
// transaction-level model (round-robin owner, ack delay vs. timeout budget).
module tb_mem_port_arbiter;

  localparam int AW      = 32;
  localparam int DW      = 32;
  localparam int TIMEOUT = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          if_ack;
  logic          if_err;
  logic          dm_req;
  logic          dm_we;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_wdata;
  logic [DW-1:0] dm_rdata;
  logic          dm_ack;
  logic          dm_err;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ack;
  logic          grant_dm;

  int vec_cnt = 0;
  int err_cnt = 0;

  logic          if_pend;
  logic          dm_pend;
  logic          last_dm;
  logic [DW-1:0] if_rd_exp;
  logic [DW-1:0] dm_rd_exp;

  always #5 clk = ~clk;

  mem_port_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
    .clk      (clk),
    .reset    (reset),
    .if_req   (if_req),
    .if_addr  (if_addr),
    .if_rdata (if_rdata),
    .if_ack   (if_ack),
    .if_err   (if_err),
    .dm_req   (dm_req),
    .dm_we    (dm_we),
    .dm_addr  (dm_addr),
    .dm_wdata (dm_wdata),
    .dm_rdata (dm_rdata),
    .dm_ack   (dm_ack),
    .dm_err   (dm_err),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .mem_ack  (mem_ack),
    .grant_dm (grant_dm)
  );

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Raise a request on each asked-for port that is not already waiting.
  task automatic applyStimulus(input logic want_if, input logic want_dm);
    if (want_if && !if_pend) begin
      if_pend = 1'b1;
      if_req  = 1'b1;
      if_addr = $urandom();
    end
    if (want_dm && !dm_pend) begin
      dm_pend  = 1'b1;
      dm_req   = 1'b1;
      dm_we    = 1'($urandom_range(0, 1));
      dm_addr  = $urandom();
      dm_wdata = $urandom();
    end
  endtask

  task automatic check_quiet(input string where);
    checkOutput({where, "_mem_req"}, 64'(mem_req), 64'(0));
    checkOutput({where, "_if_ack"}, 64'(if_ack), 64'(0));
    checkOutput({where, "_dm_ack"}, 64'(dm_ack), 64'(0));
    checkOutput({where, "_if_err"}, 64'(if_err), 64'(0));
    checkOutput({where, "_dm_err"}, 64'(dm_err), 64'(0));
    checkOutput({where, "_if_rdata"}, 64'(if_rdata), 64'(if_rd_exp));
    checkOutput({where, "_dm_rdata"}, 64'(dm_rdata), 64'(dm_rd_exp));
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    if_req    = 1'b0;
    if_addr   = '0;
    dm_req    = 1'b0;
    dm_we     = 1'b0;
    dm_addr   = '0;
    dm_wdata  = '0;
    mem_rdata = '0;
    mem_ack   = 1'b0;
    if_pend   = 1'b0;
    dm_pend   = 1'b0;
    last_dm   = 1'b1;
    if_rd_exp = '0;
    dm_rd_exp = '0;
    repeat (2) @(negedge clk);
    check_quiet("rst");
    checkOutput("rst_mem_we", 64'(mem_we), 64'(0));
    checkOutput("rst_mem_addr", 64'(mem_addr), 64'(0));
    checkOutput("rst_mem_wdata", 64'(mem_wdata), 64'(0));
    checkOutput("rst_grant_dm", 64'(grant_dm), 64'(0));
    reset = 1'b0;
  endtask

  // Called at an IDLE-cycle negedge with at least one request pending; returns at the next IDLE negedge.
  task automatic run_txn(input int ack_delay);
    logic          exp_dm;
    logic          exp_we;
    logic          exp_err;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_wdata;
    logic [DW-1:0] rd;
    int            limit;
    if (if_pend && dm_pend) exp_dm = ~last_dm;
    else                    exp_dm = dm_pend;
    last_dm   = exp_dm;
    exp_addr  = exp_dm ? dm_addr : if_addr;
    exp_we    = exp_dm && dm_we;
    exp_wdata = dm_wdata;
    exp_err   = (ack_delay > TIMEOUT);
    limit     = exp_err ? TIMEOUT : ack_delay;
    rd        = $urandom();
    for (int k = 1; k <= limit; k++) begin
      @(negedge clk);
      if (k == 1) checkOutput("grant_dm", 64'(grant_dm), 64'(exp_dm));
      checkOutput("busy_mem_req", 64'(mem_req), 64'(1));
      checkOutput("busy_mem_addr", 64'(mem_addr), 64'(exp_addr));
      checkOutput("busy_mem_we", 64'(mem_we), 64'(exp_we));
      if (exp_we) checkOutput("busy_mem_wdata", 64'(mem_wdata), 64'(exp_wdata));
      checkOutput("busy_acks", 64'(if_ack | dm_ack), 64'(0));
      mem_ack   = (k == ack_delay);
      mem_rdata = (k == ack_delay) ? rd : DW'($urandom());
    end
    @(negedge clk);
    mem_ack = 1'b0;
    checkOutput("resp_mem_req", 64'(mem_req), 64'(0));
    if (exp_dm) begin
      dm_rd_exp = (exp_err || exp_we) ? '0 : rd;
      checkOutput("resp_dm_ack", 64'(dm_ack), 64'(1));
      checkOutput("resp_dm_err", 64'(dm_err), 64'(exp_err));
      checkOutput("resp_if_ack", 64'(if_ack), 64'(0));
      checkOutput("resp_if_err", 64'(if_err), 64'(0));
      dm_req  = 1'b0;
      dm_pend = 1'b0;
    end else begin
      if_rd_exp = exp_err ? '0 : rd;
      checkOutput("resp_if_ack", 64'(if_ack), 64'(1));
      checkOutput("resp_if_err", 64'(if_err), 64'(exp_err));
      checkOutput("resp_dm_ack", 64'(dm_ack), 64'(0));
      checkOutput("resp_dm_err", 64'(dm_err), 64'(0));
      if_req  = 1'b0;
      if_pend = 1'b0;
    end
    checkOutput("resp_if_rdata", 64'(if_rdata), 64'(if_rd_exp));
    checkOutput("resp_dm_rdata", 64'(dm_rdata), 64'(dm_rd_exp));
    @(negedge clk);
    check_quiet("idle");
  endtask

  initial begin
    do_reset();

    // First contested arbitration after reset goes to if, then dm.
    applyStimulus(1'b1, 1'b1);
    run_txn(2);
    run_txn(1);

    // Timeout on a dm read, then an ack landing in the last legal BUSY cycle.
    applyStimulus(1'b0, 1'b1);
    dm_we = 1'b0;
    run_txn(TIMEOUT + 5);
    applyStimulus(1'b1, 1'b0);
    run_txn(TIMEOUT);

    // Stray ack while idle must not produce anything.
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    check_quiet("stray");

    // Reset in the third BUSY cycle discards the transaction.
    applyStimulus(1'b1, 1'b1);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("midrst_mem_req", 64'(mem_req), 64'(0));
    checkOutput("midrst_acks", 64'(if_ack | dm_ack), 64'(0));
    checkOutput("midrst_grant_dm", 64'(grant_dm), 64'(0));
    reset     = 1'b0;
    last_dm   = 1'b1;
    if_rd_exp = '0;
    dm_rd_exp = '0;
    run_txn(1);
    run_txn(3);

    for (int i = 0; i < 300; i++) begin
      applyStimulus($urandom_range(0, 2) != 0, $urandom_range(0, 2) != 0);
      mem_ack   = ($urandom_range(0, 3) == 0);
      mem_rdata = $urandom();
      if (if_pend || dm_pend) begin
        run_txn($urandom_range(1, TIMEOUT + 3));
      end else begin
        @(negedge clk);
        mem_ack = 1'b0;
        check_quiet("noreq");
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Arbitrates a single-ported unified memory between two requesters: the instruction-fetch port (if_*) and the data-memory port (dm_*) of the multicycle core.
- Sits between the core controller/datapath and the memory model.
- Gives each transaction exclusive ownership until the memory acks or a timeout fires.
- Uses round-robin priority so neither port starves.

Parameters:
- AW, 32, address width.
- DW, 32, data width.
- TIMEOUT, 16, maximum BUSY cycles waiting for mem_ack before abort; legal range 2..255.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- if_req  in  1  fetch request; held until if_ack.
- if_addr  in  AW  fetch address; stable while if_req.
- if_rdata  out  DW  fetch read data; valid when if_ack.
- if_ack  out  1  one-cycle completion pulse.
- if_err  out  1  timeout flag; valid with if_ack.
- dm_req  in  1  data request; held until dm_ack.
- dm_we  in  1  1 = write, 0 = read.
- dm_addr  in  AW  data address.
- dm_wdata  in  DW  write data.
- dm_rdata  out  DW  read data; valid when dm_ack.
- dm_ack  out  1  one-cycle completion pulse.
- dm_err  out  1  timeout flag; valid with dm_ack.
- mem_req  out  1  request to memory; held until mem_ack or abort.
- mem_we  out  1  write enable to memory.
- mem_addr  out  AW  latched address.
- mem_wdata  out  DW  latched write data.
- mem_rdata  in  DW  memory read data; valid with mem_ack.
- mem_ack  in  1  memory completion; sampled only in BUSY.
- grant_dm  out  1  owner of the current or last transaction: 1 = dm, 0 = if.

Behaviour:
- All outputs are registered.
- Reset values:
  - state = IDLE.
  - All outputs are 0, including mem_addr, mem_wdata, if_rdata and dm_rdata.
  - last_grant = dm, so the first contested arbitration goes to if.
  - Timeout counter = 0.
- FSM states are IDLE, BUSY and RESP.
- IDLE:
  - No request: stay in IDLE.
  - Exactly one request: grant it.
  - Both requesting: grant the port not equal to last_grant.
  - On grant, at the same edge:
    - Latch the address (plus we/wdata for dm; if is always a read, so mem_we = 0).
    - Set grant_dm and update last_grant.
    - Set mem_req = 1, clear the counter, go to BUSY.
  - mem_req is therefore first high in cycle N+1 for a request sampled at edge N.
- BUSY:
  - mem_req, mem_we, mem_addr and mem_wdata are held constant.
  - The counter increments each cycle.
  - mem_ack = 1:
    - Capture mem_rdata into the granted port's rdata; capture 0 for dm writes.
    - Clear mem_req, go to RESP, err = 0.
  - No mem_ack and counter == TIMEOUT-1:
    - Clear mem_req.
    - Load the granted port's rdata with 0, set err = 1, go to RESP.
  - mem_ack takes precedence over timeout in the same cycle.
- RESP:
  - The granted port's ack = 1 for exactly one cycle; err is valid alongside it.
  - Always returns to IDLE next.
  - ack and err clear on leaving RESP. rdata holds until the next completion on that port.
- Requester contract:
  - Deassert req at the edge that samples ack, so req is low in the following IDLE cycle.
  - A requester that keeps req high is treated as a new request in IDLE.
- Minimum latency:
  - Request sampled at edge 0, mem_req in cycle 1, mem_ack in cycle 1, port ack in cycle 2.
  - That is 3 cycles from req rise to ack, plus one IDLE cycle between back-to-back transactions.
- Ignored conditions:
  - mem_ack in IDLE or RESP is ignored.
  - Changes to the non-granted port's inputs during BUSY/RESP are ignored.
- Reset mid-transaction:
  - A synchronous reset during BUSY drops mem_req at that edge and discards the transaction.
  - No ack is issued.
- The non-granted port's ack and err are never asserted.

Test Plan:
- Single fetch: if_req=1, if_addr=0x100; mem_ack in the 2nd BUSY cycle with mem_rdata=0xE3A00001 -> mem_req high 2 cycles with mem_addr=0x100, mem_we=0; if_ack 1-cycle pulse with if_rdata=0xE3A00001, if_err=0.
- Data write: dm_req=1, dm_we=1, dm_addr=0x40, dm_wdata=0xDEADBEEF, mem_ack immediate -> mem_we=1, mem_wdata=0xDEADBEEF; dm_ack at cycle 2 after req; if_ack stays 0.
- Contention round-robin: both req high from reset, 2 transactions each -> grant order if, dm, if, dm (grant_dm 0,1,0,1); one IDLE cycle between transactions.
- Timeout: dm read, mem_ack never -> mem_req high exactly 16 cycles (TIMEOUT=16), then dm_ack=1, dm_err=1, dm_rdata=0; a following if read completes normally.
- Ack/timeout collision plus stray ack: mem_ack exactly in BUSY cycle 16 -> err=0 and data captured; mem_ack pulsed in IDLE -> no ack output, state unchanged.
- Reset mid-op: reset in the 3rd BUSY cycle -> mem_req=0 at the next edge, no if_ack/dm_ack, first post-reset contested grant goes to if.
